// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
package imem_arb_pkg;

  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic {
    NORM = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    FETCH  = 2'd1,
    LOADER = 2'd2
  } owner_e;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating count of fetch wins over a pending loader request; force_c
// tells the arbiter to hand the next slot to the loader.
module imem_arb_starve_ctr
  import imem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic l_req,
  input  logic f_gnt,
  input  logic l_gnt,
  output logic force_c
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!l_req || l_gnt) begin
      cnt <= '0;
    end else if (f_gnt && (cnt != CNT_W'(STARVE_MAX))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign force_c = (cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between fetch and the loader.
// Optional IMEM_ARB_STATS_EN adds fetch-stall and forced-grant counters.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [31:0]       l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_fetch_stall,
  output logic [15:0]       stat_force_cnt
`endif
);

  arb_state_e        state, state_nxt;
  owner_e            owner, owner_nxt;
  logic              force_c;
  logic              locked;
  logic [ADDR_W-1:0] f_idx, l_idx;
  logic [DATA_W-1:0] f_hold, l_hold;
  logic              unused_addr_bits;

  assign f_idx = f_addr[ADDR_W+1:2];
  assign l_idx = l_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0],
                              l_addr[31:ADDR_W+2], l_addr[1:0]};

  imem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .l_req  (l_req),
    .f_gnt  (f_gnt),
    .l_gnt  (l_gnt),
    .force_c(force_c)
  );

  // State and response-owner registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= NORM;
      owner <= NONE;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Grant decision, lock transitions and next response owner
  always_comb begin
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    state_nxt = state;
    owner_nxt = NONE;
    // A dropped lock releases the port in the same cycle
    locked    = (state == LOCK) && l_lock;

    if (locked) begin
      l_gnt = l_req;
    end else if (l_req && (!f_req || force_c)) begin
      l_gnt = 1'b1;
    end else begin
      f_gnt = f_req;
    end

    case (state)
      NORM:    if (l_gnt && l_lock) state_nxt = LOCK;
      LOCK:    if (!l_lock) state_nxt = NORM;
      default: state_nxt = NORM;
    endcase

    if (f_gnt) begin
      owner_nxt = FETCH;
    end else if (l_gnt && !l_we) begin
      owner_nxt = LOADER;
    end
  end

  assign mem_en    = f_gnt | l_gnt;
  assign mem_we    = l_gnt & l_we;
  assign mem_addr  = l_gnt ? l_idx : f_idx;
  assign mem_wdata = l_wdata;

  // Hold last delivered word per requester between responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_hold <= '0;
      l_hold <= '0;
    end else begin
      if (owner == FETCH)  f_hold <= mem_rdata;
      if (owner == LOADER) l_hold <= mem_rdata;
    end
  end

  assign f_rvalid = (owner == FETCH);
  assign l_rvalid = (owner == LOADER);
  assign f_rdata  = f_rvalid ? mem_rdata : f_hold;
  assign l_rdata  = l_rvalid ? mem_rdata : l_hold;

`ifdef IMEM_ARB_STATS_EN
  logic forced;

  assign forced = l_gnt && f_req && force_c && !locked;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetch_stall <= '0;
      stat_force_cnt   <= '0;
    end else begin
      if (f_req && !f_gnt && (stat_fetch_stall != 16'hFFFF))
        stat_fetch_stall <= stat_fetch_stall + 16'd1;
      if (forced && (stat_force_cnt != 16'hFFFF))
        stat_force_cnt <= stat_force_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter with a behavioural 1-cycle memory.
// Define IMEM_ARB_STATS_EN to also cover the statistics counters.
module tb_imem_port_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic              clk, rst;
  logic              f_req, f_gnt, f_rvalid;
  logic [31:0]       f_addr;
  logic [DATA_W-1:0] f_rdata;
  logic              l_req, l_we, l_lock, l_gnt, l_rvalid;
  logic [31:0]       l_addr;
  logic [DATA_W-1:0] l_wdata, l_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef IMEM_ARB_STATS_EN
  logic [15:0]       stat_fetch_stall, stat_force_cnt;
`endif

  imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_STATS_EN
    , .stat_fetch_stall(stat_fetch_stall), .stat_force_cnt(stat_force_cnt)
`endif
  );

  typedef struct {
    logic        is_fetch;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exp_stall = 0;
  int          exp_force = 0;
  logic [31:0] mem[1024];
  logic [31:0] ref_mem[1024];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural single-port memory with registered read data
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Scoreboard: responses due one cycle after each granted read
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      sb.delete();
      check("rst_f_rvalid", 32'(f_rvalid), 32'd0);
      check("rst_l_rvalid", 32'(l_rvalid), 32'd0);
    end else begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        if (e.is_fetch) begin
          check("sb_f_rvalid", 32'(f_rvalid), 32'd1);
          check("sb_l_rvalid_quiet", 32'(l_rvalid), 32'd0);
          check("sb_f_rdata", f_rdata, e.data);
        end else begin
          check("sb_l_rvalid", 32'(l_rvalid), 32'd1);
          check("sb_f_rvalid_quiet", 32'(f_rvalid), 32'd0);
          check("sb_l_rdata", l_rdata, e.data);
        end
      end else begin
        check("idle_f_rvalid", 32'(f_rvalid), 32'd0);
        check("idle_l_rvalid", 32'(l_rvalid), 32'd0);
      end
      if (f_gnt) sb.push_back('{1'b1, ref_mem[f_addr[11:2]], cyc + 1});
      if (l_gnt && !l_we) sb.push_back('{1'b0, ref_mem[l_addr[11:2]], cyc + 1});
      if (l_gnt && l_we) ref_mem[l_addr[11:2]] = l_wdata;
    end
  end

  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lwe,
                       input logic llk, input logic [31:0] la, input logic [31:0] lwd);
    f_req = fr; f_addr = fa; l_req = lr; l_we = lwe; l_lock = llk; l_addr = la; l_wdata = lwd;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = seed_word(i);
      ref_mem[i] = seed_word(i);
    end
    mem_rdata = '0;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_f_rdata", f_rdata, 32'd0);
    check("reset_l_rdata", l_rdata, 32'd0);
    check("reset_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Fetch-only back-to-back reads
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(4 * i), 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t1_f_gnt", 32'(f_gnt), 32'd1);
      check("t1_mem_addr", 32'(mem_addr), 32'(i));
      next_cycle;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle;

    // Loader write, then readback
    drive(0, 0, 1, 1, 0, 32'h8, 32'hDEADBEEF);
    @(negedge clk);
    check("t5_l_gnt", 32'(l_gnt), 32'd1);
    check("t5_mem_we", 32'(mem_we), 32'd1);
    check("t5_mem_addr", 32'(mem_addr), 32'd2);
    next_cycle;
    drive(0, 0, 1, 0, 0, 32'h8, 0);
    @(negedge clk);
    check("t5_rd_gnt", 32'(l_gnt), 32'd1);
    next_cycle;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t5_readback", l_rdata, 32'hDEADBEEF);
    next_cycle;

    // Starvation: four fetch wins, then the loader is forced in
    drive(1, 32'h20, 1, 0, 0, 32'h40, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_fetch_wins", 32'(f_gnt), 32'd1);
      check("t2_loader_waits", 32'(l_gnt), 32'd0);
      next_cycle;
    end
    @(negedge clk);
    check("t2_forced_l_gnt", 32'(l_gnt), 32'd1);
    check("t2_forced_f_gnt", 32'(f_gnt), 32'd0);
    exp_stall++;
    exp_force++;
    next_cycle;
    drive(1, 32'h24, 1, 0, 0, 32'h44, 0);
    @(negedge clk);
    check("t2_l_rdata", l_rdata, seed_word(16));
    check("t2_cnt_cleared", 32'(f_gnt), 32'd1);
    next_cycle;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef IMEM_ARB_STATS_EN
    check("t6_force_after_t2", 32'(stat_force_cnt), 32'(exp_force));
`endif
    next_cycle;

    // Lock burst: first write wins by starvation, the rest own the port
    drive(1, 32'h100, 1, 1, 1, 32'h100, 32'h1000);
    n = 0;
    @(negedge clk);
    while (!l_gnt && n < 10) begin
      next_cycle;
      @(negedge clk);
      n++;
    end
    check("t3_first_gnt_wait", 32'(n), 32'd4);
    check("t3_first_we", 32'(mem_we), 32'd1);
    exp_stall++;
    exp_force++;
    next_cycle;
    for (int k = 1; k < 4; k++) begin
      drive(1, 32'h100, 1, 1, 1, 32'(32'h100 + 4 * k), 32'(32'h1000 + k));
      @(negedge clk);
      check("t3_f_blocked", 32'(f_gnt), 32'd0);
      check("t3_l_gnt", 32'(l_gnt), 32'd1);
      check("t3_mem_we", 32'(mem_we), 32'd1);
      exp_stall++;
      next_cycle;
    end
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h100, 0, 0, 1, 0, 0);
      @(negedge clk);
      check("t6_lock_hold_block", 32'(f_gnt), 32'd0);
      exp_stall++;
      next_cycle;
    end
    drive(1, 32'h100, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t3_unlock_f_gnt", 32'(f_gnt), 32'd1);
`ifdef IMEM_ARB_STATS_EN
    check("t6_stall_cnt", 32'(stat_fetch_stall), 32'(exp_stall));
    check("t6_force_cnt", 32'(stat_force_cnt), 32'(exp_force));
`endif
    next_cycle;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t3_written_word", f_rdata, 32'h1000);
    next_cycle;

    // Reset with a fetch read in flight
    drive(1, 32'hC, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t4_f_gnt", 32'(f_gnt), 32'd1);
    #2 rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t4_f_rvalid_rst", 32'(f_rvalid), 32'd0);
    check("t4_f_rdata_rst", f_rdata, 32'd0);
`ifdef IMEM_ARB_STATS_EN
    check("t4_stall_rst", 32'(stat_fetch_stall), 32'd0);
    check("t4_force_rst", 32'(stat_force_cnt), 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t4_no_rvalid_after", 32'(f_rvalid), 32'd0);
    next_cycle;

    // Reset while locked with a loader read in flight: back to NORM
    drive(0, 0, 1, 0, 1, 32'h8, 0);
    @(negedge clk);
    check("t4_lock_gnt", 32'(l_gnt), 32'd1);
    #2 rst = 1'b0;
    @(negedge clk);
    check("t4_l_rvalid_rst", 32'(l_rvalid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1, 32'h4, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("t4_state_norm", 32'(f_gnt), 32'd1);
    check("t4_l_rvalid_after", 32'(l_rvalid), 32'd0);
    next_cycle;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    next_cycle;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
